// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared types and constants for the memory dump reader.
//   state_e        - dump FSM state encoding
//   FIFO_DEPTH     - depth of the output skid FIFO (also bounds read credits)
//   DEFAULT_STRIDE - byte step between consecutive words, matches the loader
package mem_dump_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned DEFAULT_STRIDE = 4;

endpackage

// File: rtl/dump_fifo.sv
// dump_fifo: small synchronous FIFO holding words returned by memory until the
// sink accepts them. Push and pop may happen in the same cycle, also when full.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push/wdata - write request and data
//   pop        - read request; head advances on the next edge
//   rdata      - current head entry (meaningless while empty)
//   full/empty - occupancy flags
//   count      - number of stored entries
module dump_fifo
    import mem_dump_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (cnt_q != '0);
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads word_count words starting at start_addr from a
// synchronous-read memory (1-cycle latency) and streams them out over
// valid/ready. Reads are credit-limited so every returned word has a FIFO slot.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   start                  - begin a dump (ignored while busy)
//   start_addr, word_count - dump range, sampled when start is accepted
//   mem_rd_en, mem_addr    - memory read request
//   mem_rdata              - read data, valid the cycle after mem_rd_en
//   out_valid, out_data    - streamed word
//   out_ready              - sink handshake
//   busy                   - dump in progress
//   done                   - one-cycle pulse after the last word is accepted
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRIDE = DEFAULT_STRIDE,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    // Wide enough to hold fifo occupancy plus the in-flight read.
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 2);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              inflight_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic              pop;
    logic [LVL_W-1:0]  level_after_pop;
    logic              credit_ok;
    logic              final_pop;
    logic              accept_start;

    dump_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata (mem_rdata),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pop             = !fifo_empty && out_ready;
    assign level_after_pop = LVL_W'(fifo_count) - LVL_W'(pop);
    // Each outstanding word (stored or in flight) holds one FIFO slot.
    assign credit_ok       = (level_after_pop + LVL_W'(inflight_q)) < LVL_W'(FIFO_DEPTH);
    // The last word leaves the FIFO with nothing left behind it.
    assign final_pop       = pop && (fifo_count == FCNT_W'(1)) && !inflight_q;
    assign accept_start    = (state_q == StIdle) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && (word_count != '0)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mem_rd_en && (remaining_q == CNT_W'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (final_pop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != StIdle);
        mem_rd_en = (state_q == StRun) && (remaining_q != '0) && credit_ok;
        mem_addr  = mem_rd_en ? addr_q : '0;
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : fifo_head;
        done      = done_q;
    end

    // Address counter, word counter, read tracking and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= mem_rd_en;
            done_q     <= 1'b0;
            if (accept_start) begin
                addr_q      <= start_addr;
                remaining_q <= word_count;
                // An empty range completes immediately without touching memory.
                if (word_count == '0) begin
                    done_q <= 1'b1;
                end
            end else if (mem_rd_en) begin
                addr_q      <= addr_q + ADDR_W'(STRIDE);
                remaining_q <= remaining_q - CNT_W'(1);
            end
            if ((state_q == StDrain) && final_pop) begin
                done_q <= 1'b1;
            end
        end
    end

    // A returning word may only meet a full FIFO when the head leaves that cycle.
    assert property (@(posedge clk) disable iff (rst) (fifo_full && inflight_q) |-> pop);

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    mem_dump_reader #(
        .ADDR_W (32),
        .DATA_W (32),
        .STRIDE (4),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed hash of the address.
    logic [31:0] mem_seed = 32'h1234_5678;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    // Synchronous-read memory, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_word(mem_addr);
    end

    // Observations of one dump; cycle index k counts from the start cycle (k=0).
    logic [31:0] rd_q[$];
    int          rd_k[$];
    logic [31:0] got_q[$];
    int          got_k[$];
    int          done_cnt, done_k, busy_at_done, busy_seen;
    int          credit_viol, stable_viol, first_valid_k, issued, accepted;
    logic        hold_q;
    logic [31:0] hold_data;

    task automatic clear_obs();
        rd_q.delete(); rd_k.delete(); got_q.delete(); got_k.delete();
        done_cnt = 0; done_k = -1; busy_at_done = 0; busy_seen = 0;
        credit_viol = 0; stable_viol = 0; first_valid_k = -1;
        issued = 0; accepted = 0; hold_q = 1'b0; hold_data = '0;
    endtask

    // Called at the falling edge of cycle k.
    task automatic sample(input int k);
        if (hold_q && (!out_valid || out_data !== hold_data)) stable_viol++;
        hold_q    = out_valid && !out_ready;
        hold_data = out_data;
        if (mem_rd_en) begin
            // Outstanding words = FIFO contents + in-flight read; at most 2 after this pop.
            if (issued - accepted - ((out_valid && out_ready) ? 1 : 0) >= 2) credit_viol++;
            rd_q.push_back(mem_addr);
            rd_k.push_back(k);
            issued++;
        end
        if (out_valid && first_valid_k < 0) first_valid_k = k;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_k.push_back(k);
            accepted++;
        end
        if (busy) busy_seen++;
        if (done) begin
            done_cnt++;
            done_k = k;
            if (busy) busy_at_done++;
        end
    endtask

    function automatic logic ready_for(input int mode, input int k, input int stall);
        case (mode)
            0:       return 1'b1;
            1:       return (k >= stall);
            2:       return (k % 2 == 0);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Runs one dump until done (bounded) plus two trailing cycles.
    task automatic run_dump(input logic [31:0] a, input logic [15:0] n, input int mode,
                            input int stall, input bit extra, input int budget);
        int k;
        clear_obs();
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        out_ready  = ready_for(mode, 0, stall);
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            sample(k);
            if (done_cnt > 0) break;
            @(posedge clk); #1;
            k++;
            start = extra && (k == 2);
            if (start) begin
                start_addr = 32'h0000_1000;
                word_count = 16'd7;
            end
            out_ready = ready_for(mode, k, stall);
        end
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            k++;
            out_ready = ready_for(mode, k, stall);
            @(negedge clk);
            sample(k);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0 || mem_addr !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b valid=%b addr=%h data=%h, want all 0",
                     busy, done, mem_rd_en, out_valid, mem_addr, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_dump(32'd4, 16'd3, 0, 0, 1'b0, 100);
        vectors++;
        if (rd_q.size() != 3) begin
            miscompares++;
            $display("FAIL basic_reads: got %0d reads, want 3", rd_q.size());
        end
        for (int i = 0; i < rd_q.size() && i < 3; i++) begin
            vectors++;
            if (rd_q[i] !== 32'd4 + 32'(i) * 4 || rd_k[i] != i + 1) begin
                miscompares++;
                $display("FAIL basic_read%0d: addr %h at k=%0d, want %h at k=%0d",
                         i, rd_q[i], rd_k[i], 32'd4 + 32'(i) * 4, i + 1);
            end
        end
        vectors++;
        // Issue in cycle 1, data pushed in cycle 2, visible in cycle 3.
        if (first_valid_k != 3) begin
            miscompares++;
            $display("FAIL basic_latency: first out_valid at k=%0d, want 3", first_valid_k);
        end
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL basic_words: got %0d words, want 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            vectors++;
            if (got_q[i] !== mem_word(32'd4 + 32'(i) * 4) || got_k[i] != i + 3) begin
                miscompares++;
                $display("FAIL basic_word%0d: %h at k=%0d, want %h at k=%0d", i, got_q[i],
                         got_k[i], mem_word(32'd4 + 32'(i) * 4), i + 3);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_k != 6 || busy_at_done != 0) begin
            miscompares++;
            $display("FAIL basic_done: pulses=%0d at k=%0d busy_at_done=%0d, want 1 at k=6 busy 0",
                     done_cnt, done_k, busy_at_done);
        end
        vectors++;
        if (busy_seen != 5) begin
            miscompares++;
            $display("FAIL basic_busy: busy cycles %0d, want 5", busy_seen);
        end
    endtask

    task automatic test_stall();
        int early;
        run_dump(32'h0000_0100, 16'd4, 1, 5, 1'b0, 200);
        early = 0;
        foreach (rd_k[i]) if (rd_k[i] < 5) early++;
        vectors++;
        if (early != 2) begin
            miscompares++;
            $display("FAIL stall_reads: %0d reads before ready, want 2", early);
        end
        vectors++;
        if (stable_viol != 0) begin
            miscompares++;
            $display("FAIL stall_stable: %0d out_data changes while stalled, want 0", stable_viol);
        end
        vectors++;
        if (got_q.size() != 4 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL stall_count: %0d words %0d done, want 4 words 1 done",
                     got_q.size(), done_cnt);
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            vectors++;
            if (got_q[i] !== mem_word(32'h100 + 32'(i) * 4)) begin
                miscompares++;
                $display("FAIL stall_word%0d: %h, want %h", i, got_q[i],
                         mem_word(32'h100 + 32'(i) * 4));
            end
        end
    endtask

    task automatic test_toggle();
        run_dump(32'h0000_2000, 16'd6, 2, 0, 1'b0, 200);
        vectors++;
        if (credit_viol != 0) begin
            miscompares++;
            $display("FAIL toggle_credit: %0d reads with 2 outstanding, want 0", credit_viol);
        end
        vectors++;
        if (got_q.size() != 6 || rd_q.size() != 6 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL toggle_count: %0d words %0d reads %0d done, want 6 6 1",
                     got_q.size(), rd_q.size(), done_cnt);
        end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            vectors++;
            if (got_q[i] !== mem_word(32'h2000 + 32'(i) * 4)) begin
                miscompares++;
                $display("FAIL toggle_word%0d: %h, want %h", i, got_q[i],
                         mem_word(32'h2000 + 32'(i) * 4));
            end
        end
    endtask

    task automatic test_zero_count();
        run_dump(32'h0000_0040, 16'd0, 0, 0, 1'b0, 20);
        vectors++;
        if (rd_q.size() != 0 || busy_seen != 0) begin
            miscompares++;
            $display("FAIL zero_activity: %0d reads %0d busy cycles, want 0 0",
                     rd_q.size(), busy_seen);
        end
        vectors++;
        if (done_cnt != 1 || done_k != 1) begin
            miscompares++;
            $display("FAIL zero_done: %0d pulses at k=%0d, want 1 at k=1", done_cnt, done_k);
        end
    endtask

    task automatic test_wrap_busy_start();
        run_dump(32'hFFFF_FFFC, 16'd2, 0, 0, 1'b1, 100);
        vectors++;
        if (rd_q.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_reads: %0d reads, want 2", rd_q.size());
        end else begin
            vectors++;
            if (rd_q[0] !== 32'hFFFF_FFFC || rd_q[1] !== 32'h0000_0000) begin
                miscompares++;
                $display("FAIL wrap_addrs: %h %h, want fffffffc 00000000", rd_q[0], rd_q[1]);
            end
        end
        vectors++;
        if (got_q.size() != 2 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL wrap_count: %0d words %0d done, want 2 1", got_q.size(), done_cnt);
        end else begin
            vectors++;
            if (got_q[0] !== mem_word(32'hFFFF_FFFC) || got_q[1] !== mem_word(32'h0)) begin
                miscompares++;
                $display("FAIL wrap_words: %h %h, want %h %h", got_q[0], got_q[1],
                         mem_word(32'hFFFF_FFFC), mem_word(32'h0));
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int dones;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 32'h0000_0300; word_count = 16'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        // Cycle 3: one word held, one read in flight.
        if (!out_valid || out_data !== mem_word(32'h300) || !busy) begin
            miscompares++;
            $display("FAIL rstmid_pre: valid=%b data=%h busy=%b, want 1 %h 1",
                     out_valid, out_data, busy, mem_word(32'h300));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0 || mem_addr !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: busy=%b done=%b rd_en=%b valid=%b addr=%h data=%h, want 0",
                     busy, done, mem_rd_en, out_valid, mem_addr, out_data);
        end
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || out_valid || mem_rd_en) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: %0d active cycles after reset, want 0", dones);
        end
        run_dump(32'h0000_0500, 16'd1, 0, 0, 1'b0, 50);
        vectors++;
        if (got_q.size() != 1 || done_cnt != 1 || rd_q.size() != 1) begin
            miscompares++;
            $display("FAIL rstmid_rerun: %0d words %0d reads %0d done, want 1 1 1",
                     got_q.size(), rd_q.size(), done_cnt);
        end else begin
            vectors++;
            if (got_q[0] !== mem_word(32'h500)) begin
                miscompares++;
                $display("FAIL rstmid_word: %h, want %h", got_q[0], mem_word(32'h500));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            logic [31:0] a;
            logic [15:0] n;
            int          bad;
            a = $urandom() & 32'hFFFF_FFFC;
            n = 16'($urandom_range(1, 12));
            run_dump(a, n, 3, 0, 1'b0, 400);
            bad = 0;
            for (int i = 0; i < got_q.size(); i++)
                if (got_q[i] !== mem_word(a + 32'(i) * 4)) bad++;
            vectors++;
            if (got_q.size() != int'(n) || bad != 0 || done_cnt != 1) begin
                miscompares++;
                $display("FAIL rand%0d_stream: %0d words %0d wrong %0d done, want %0d 0 1",
                         r, got_q.size(), bad, done_cnt, n);
            end
            vectors++;
            if (credit_viol != 0 || stable_viol != 0) begin
                miscompares++;
                $display("FAIL rand%0d_rules: credit=%0d stable=%0d, want 0 0",
                         r, credit_viol, stable_viol);
            end
        end
    endtask

    initial begin
        mem_seed = $urandom();
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_zero_count();
        test_wrap_busy_start();
        test_reset_mid_dump();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
